// File: rtl/eviction_write_buffer.sv
// eviction_write_buffer
//   Holds dirty lines evicted by the L2 so a miss can fetch its new line
//   before the victim is written back. Lines drain to memory in FIFO order
//   whenever the L2 side is idle. L2 reads that hit a buffered line are
//   served from the buffer, so memory is never read stale.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_*             L2-facing line port (request held until mem_resp)
//   pmem_*            cacheline_adaptor-facing line port (held until pmem_resp)
module eviction_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic              mem_resp,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);
    localparam int TAG_W = ADDR_W - 5;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD_MEM, S_WB_MEM, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [LINE_W-1:0]  r_line [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head, r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [LINE_W-1:0]  r_rdata;
    logic [ADDR_W-1:0]  r_paddr;
    logic [LINE_W-1:0]  r_pwdata;

    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [PTR_W-1:0]   w_hit_idx;
    logic               w_full;
    logic               w_rd_hit, w_rd_miss, w_rd_done;
    logic               w_wr_hit, w_push, w_drain_start, w_pop;

    assign w_tag  = mem_address[ADDR_W-1:5];
    assign w_full = (r_count == CNT_W'(DEPTH));

    // Writes coalesce, so at most one valid entry carries a given tag.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_tag[i] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_rd_hit      = 1'b0;
        w_rd_miss     = 1'b0;
        w_rd_done     = 1'b0;
        w_wr_hit      = 1'b0;
        w_push        = 1'b0;
        w_drain_start = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Read has priority; a simultaneous write is illegal anyway.
                if (mem_read) begin
                    if (w_hit) begin
                        w_rd_hit = 1'b1;
                        w_next   = S_RESP;
                    end else begin
                        w_rd_miss = 1'b1;
                        w_next    = S_RD_MEM;
                    end
                end else if (mem_write) begin
                    if (w_hit) begin
                        w_wr_hit = 1'b1;
                        w_next   = S_RESP;
                    end else if (!w_full) begin
                        w_push = 1'b1;
                        w_next = S_RESP;
                    end else begin
                        // Full: free the head, then re-evaluate the held write.
                        w_drain_start = 1'b1;
                        w_next        = S_WB_MEM;
                    end
                end else if (r_count != '0) begin
                    w_drain_start = 1'b1;
                    w_next        = S_WB_MEM;
                end
            end
            S_RD_MEM: begin
                if (pmem_resp) begin
                    w_rd_done = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_WB_MEM: begin
                if (pmem_resp) begin
                    w_pop  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Line storage carries no reset; r_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_wr_hit)
            r_line[w_hit_idx] <= mem_wdata;
        if (w_push) begin
            r_tag[r_tail]  <= w_tag;
            r_line[r_tail] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
                r_count         <= r_count + CNT_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
                r_count         <= r_count - CNT_W'(1);
            end
            if (w_drain_start) begin
                r_paddr  <= {r_tag[r_head], 5'b0};
                r_pwdata <= r_line[r_head];
            end
            if (w_rd_miss)
                r_paddr <= {w_tag, 5'b0};
            if (w_rd_hit)
                r_rdata <= r_line[w_hit_idx];
            if (w_rd_done)
                r_rdata <= pmem_rdata;
        end
    end

    assign mem_resp     = (r_state == S_RESP);
    assign pmem_read    = (r_state == S_RD_MEM);
    assign pmem_write   = (r_state == S_WB_MEM);
    assign mem_rdata    = r_rdata;
    assign pmem_address = r_paddr;
    assign pmem_wdata   = r_pwdata;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// tb_eviction_write_buffer
//   Drives the L2 side with directed and random line traffic, emulates the
//   cacheline_adaptor with a variable-latency memory, and checks responses
//   and drains against a queue-based model of the buffer contents.
module tb_eviction_write_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_wdata = '0;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp = 1'b0;
    logic [255:0] pmem_rdata = '0;

    eviction_write_buffer #(.DEPTH(4), .ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [26:0] tag; logic [255:0] line; } ent_t;
    typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } op_t;

    ent_t         mq[$];                  // model of buffered lines, FIFO order
    op_t          ops[$];                 // completed pmem transactions
    logic [255:0] backmem [logic [26:0]];

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int lat_min = 0, lat_max = 0;
    int resp_cyc = 0, last_resp_cyc = 0;
    logic [31:0] exp_rd_addr = '0;
    bit rsp_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_val(input logic [26:0] t);
        if (backmem.exists(t)) return backmem[t];
        return {8{32'hC0DE_0000 ^ {5'b0, t}}};
    endfunction

    function automatic int find(input logic [26:0] t);
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Memory side: accept a transaction, wait a random latency, pulse resp.
    initial begin
        int cnt;
        logic [31:0]  cap_a;
        logic [255:0] cap_d;
        bit cap_w;
        cnt = 0; cap_a = '0; cap_d = '0; cap_w = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pmem_resp = 1'b0;
                rsp_busy  = 1'b0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!rsp_busy) begin
                    rsp_busy = 1'b1;
                    cnt   = $urandom_range(lat_max, lat_min);
                    cap_a = pmem_address;
                    cap_d = pmem_wdata;
                    cap_w = pmem_write;
                    chk("pmem_one_cmd", {pmem_read, pmem_write}, cap_w ? 2'b01 : 2'b10);
                end else begin
                    chk("pmem_addr_stable", pmem_address, cap_a);
                end
                if (cnt == 0) begin
                    if (cap_w) begin
                        ops.push_back('{1'b1, cap_a, cap_d});
                        chk("drain_nonempty", 256'(mq.size() > 0), 256'(1));
                        if (mq.size() > 0) begin
                            chk("drain_addr", cap_a, {mq[0].tag, 5'b0});
                            chk("drain_data", cap_d, mq[0].line);
                            mq.delete(0);
                        end
                        backmem[cap_a[31:5]] = cap_d;
                    end else begin
                        ops.push_back('{1'b0, cap_a, '0});
                        chk("rdmiss_addr", cap_a, exp_rd_addr);
                        chk("rdmiss_not_buffered", 256'(find(cap_a[31:5]) < 0), 256'(1));
                        pmem_rdata = mem_val(cap_a[31:5]);
                    end
                    pmem_resp = 1'b1;
                    resp_cyc  = cyc;
                    rsp_busy  = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // One L2 request; returns at the negedge where mem_resp was seen, with the
    // request already dropped so a following call issues back-to-back.
    task automatic req(input bit wr, input logic [31:0] a, input logic [255:0] d, output int lat);
        int n, idx;
        mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata = d;
        if (!wr) exp_rd_addr = {a[31:5], 5'b0};
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (mem_resp) break;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        lat = n;
        last_resp_cyc = cyc;
        chk("resp_timeout", mem_resp, 1'b1);
        if (!mem_resp) return;
        idx = find(a[31:5]);
        if (wr) begin
            if (idx >= 0) mq[idx].line = d;
            else          mq.push_back('{a[31:5], d});
        end else begin
            chk("rdata", mem_rdata, (idx >= 0) ? mq[idx].line : mem_val(a[31:5]));
        end
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((mq.size() != 0 || pmem_write || pmem_read || rsp_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 256'(mq.size()), 256'(0));
        repeat (3) @(negedge clk);
        chk("quiet_after_drain", {pmem_read, pmem_write}, 2'b00);
    endtask

    initial begin
        int n, n0, nrd;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset and idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {mem_resp, pmem_read, pmem_write, |mem_rdata, |pmem_address, |pmem_wdata}, '0);
        end
        chk("idle_no_pmem", 256'(ops.size()), 256'(0));

        // write accept with memory stalled, then idle drain
        lat_min = 30; lat_max = 30;
        req(1'b1, 32'h0000_1040, {8{32'hA5A5_A5A5}}, n);
        chk("wr_lat", 256'(n), 256'(1));
        @(negedge clk);
        chk("drain_not_yet", pmem_write, 1'b0);
        @(negedge clk);
        chk("drain_start", pmem_write, 1'b1);
        chk("drain_start_a", pmem_address, 32'h0000_1040);
        chk("drain_start_d", pmem_wdata, {8{32'hA5A5_A5A5}});
        wait_drained();
        chk("drain_one", 256'(ops.size()), 256'(1));

        // read hit from buffer
        lat_min = 3; lat_max = 3;
        n0 = ops.size();
        req(1'b1, 32'h2000, 256'd1, n);
        req(1'b0, 32'h2010, '0, n);
        chk("rdhit_lat", 256'(n), 256'(2));
        chk("rdhit_data", mem_rdata, 256'd1);
        wait_drained();
        nrd = 0;
        for (int i = n0; i < ops.size(); i++) if (!ops[i].wr) nrd++;
        chk("rdhit_no_pmem_read", 256'(nrd), 256'(0));

        // coalescing
        n0 = ops.size();
        req(1'b1, 32'h3000, 256'd1, n);
        req(1'b1, 32'h3000, 256'd2, n);
        wait_drained();
        chk("coalesce_cnt", 256'(ops.size() - n0), 256'(1));
        if (ops.size() > n0) begin
            chk("coalesce_a", ops[n0].addr, 32'h3000);
            chk("coalesce_d", ops[n0].data, 256'd2);
        end

        // full buffer forces a drain of the oldest line
        lat_min = 10; lat_max = 10;
        n0 = ops.size();
        for (int i = 1; i <= 4; i++) req(1'b1, 32'(i * 32'h100), 256'(i), n);
        chk("fill_no_drain", 256'(ops.size() - n0), 256'(0));
        req(1'b1, 32'h500, 256'd5, n);
        chk("full_stall", 256'(n > 10), 256'(1));
        chk("forced_drain_cnt", 256'(ops.size() - n0), 256'(1));
        if (ops.size() > n0) chk("forced_drain_a", ops[n0].addr, 32'h100);
        wait_drained();
        chk("fifo_drain_cnt", 256'(ops.size() - n0), 256'(5));
        for (int i = 1; i < 5 && n0 + i < ops.size(); i++)
            chk("fifo_order", ops[n0 + i].addr, 32'((i + 1) * 32'h100));

        // read miss bypasses pending drain
        lat_min = 5; lat_max = 5;
        n0 = ops.size();
        req(1'b1, 32'h4000, 256'h44, n);
        req(1'b0, 32'h8000, '0, n);
        chk("rdmiss_lat", 256'(last_resp_cyc - resp_cyc), 256'(1));
        chk("rdmiss_data", mem_rdata, {8{32'hC0DE_0000 ^ 32'(32'h8000 >> 5)}});
        wait_drained();
        if (ops.size() >= n0 + 2) begin
            chk("rdmiss_first", {31'b0, ops[n0].wr, ops[n0].addr}, {32'b0, 32'h8000});
            chk("rdmiss_then_drain", {31'b0, ops[n0+1].wr, ops[n0+1].addr}, {31'b0, 1'b1, 32'h4000});
        end else begin
            chk("rdmiss_ops", 256'(ops.size() - n0), 256'(2));
        end

        // random traffic over a small tag pool
        lat_min = 0; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            a = 32'h0001_0000 | {$urandom_range(0, 9), 5'b0} | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 6) req(1'b1, a, rnd_line(), n);
            else                          req(1'b0, a, '0, n);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drained();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/eviction_write_buffer.md
Name: eviction_write_buffer

Overview:
Buffers dirty 256-bit lines evicted by the L2 (cache_L2) and sits between the L2's pmem port and the cacheline_adaptor. Accepts L2 write-backs in one cycle so an L2 miss can fetch its new line first. Drains buffered lines to memory when the L2 side is idle. Serves L2 reads that hit a buffered line directly from the buffer, which keeps the design coherent.

Parameters:
DEPTH, 4, number of line entries (power of two, >=2)
ADDR_W, 32, address width
LINE_W, 256, cacheline width in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  L2 line read request, held until mem_resp
mem_write  in  1  L2 line write-back request, held until mem_resp
mem_address  in  ADDR_W  L2 request address; bits [4:0] ignored
mem_wdata  in  LINE_W  write-back line
mem_resp  out  1  one-cycle completion pulse to L2
mem_rdata  out  LINE_W  read line, valid while mem_resp=1
pmem_read  out  1  line read to cacheline_adaptor, held until pmem_resp
pmem_write  out  1  line write to cacheline_adaptor, held until pmem_resp
pmem_address  out  ADDR_W  line-aligned address, bits [4:0]=0
pmem_wdata  out  LINE_W  line being drained
pmem_resp  in  1  cacheline_adaptor completion pulse
pmem_rdata  in  LINE_W  line from memory, valid with pmem_resp

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Storage: DEPTH-entry circular FIFO of {tag = address[31:5], line}, with head/tail pointers and a count. Pointers wrap modulo DEPTH.
- Address match: per-entry valid compare of mem_address[31:5] against the stored tag. At most one entry can match, because writes coalesce.
- States: IDLE, RD_MEM, WB_MEM, RESP.
- IDLE, evaluated in priority order:
  - mem_read with a hit: capture the entry's line into mem_rdata; go to RESP.
  - mem_read with a miss: latch pmem_address = {mem_address[31:5], 5'b0}; go to RD_MEM.
  - mem_write with a hit: overwrite that entry's line in place (count unchanged); go to RESP.
  - mem_write with a miss and count<DEPTH: push at tail; go to RESP.
  - mem_write with a miss and count==DEPTH: go to WB_MEM (forced drain). The write is re-evaluated when the drain returns to IDLE.
  - No request and count>0: go to WB_MEM.
  - Otherwise stay in IDLE.
  - mem_read and mem_write together is illegal; read wins.
- WB_MEM:
  - On entry, pmem_address = {head tag, 5'b0} and pmem_wdata = head line.
  - pmem_write=1 until pmem_resp.
  - On pmem_resp: pop head (count-1); go to IDLE.
  - Non-preemptible: L2 requests wait.
- RD_MEM:
  - pmem_read=1 until pmem_resp.
  - On pmem_resp: mem_rdata <= pmem_rdata; go to RESP.
- RESP:
  - mem_resp=1 for exactly one cycle, then IDLE.
  - The L2 drops its request in the same cycle, so no double-accept.
- Latency:
  - Write accept or read hit: request seen in IDLE at cycle T gives mem_resp at T+1.
  - Read miss: pmem_read asserted from T+1; pmem_resp at cycle R gives mem_resp at R+1.
  - Idle drain starts (pmem_write=1) the cycle after IDLE with no request and count>0.
- Output driving:
  - pmem_read, pmem_write and mem_resp decode from the state register only; there is no combinational path from mem_* to pmem_*.
  - pmem_address, pmem_wdata and mem_rdata are registers, held stable for the whole transaction.
- Reset:
  - State IDLE; count, head and tail 0; all entries invalid.
  - mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata and mem_rdata all 0.
  - Reset mid-transaction abandons it; buffered lines are lost. This is allowed only at system reset.
- Ordering: lines drain in FIFO order. A read miss can never target a buffered line, so bypassing the drain is safe.

Test Plan:
- Reset, then idle: all outputs 0 for 10 cycles; no pmem activity.
- Write 0x0000_1040 (line A5A5...) with memory stalled: mem_resp at T+1. Then pmem_write with pmem_address=0x0000_1040 and pmem_wdata=A5A5... the cycle after the request drops; count returns to 0 after pmem_resp.
- Write 0x2000 (line=1), then read 0x2010 before the drain: mem_resp at T+1 with mem_rdata=1; pmem_read never asserts.
- Write 0x3000 (line=1), then write 0x3000 (line=2), with drain held off by back-to-back requests: one entry only. A single pmem_write to 0x3000 with data 2.
- DEPTH+1 writes to 0x100, 0x200, ..., 0x500 with a 10-cycle pmem_resp latency: the 5th write stalls, a forced drain of 0x100 completes, then the 5th write gets mem_resp. Drain order is 0x200, 0x300, 0x400, 0x500.
- Buffer holds 0x4000, then read miss 0x8000: pmem_read for 0x8000 occurs before any pmem_write. mem_rdata = pmem_rdata one cycle after pmem_resp; the drain of 0x4000 follows.
